// File: rtl/nw_fill_ctrl.sv
// Address/control sequencer for the Needleman-Wunsch score RAM: writes the gap-penalty
// border (row 0 / column 0), then walks interior cells read -> compute -> write.
module nw_fill_ctrl #(
  parameter int N       = 128,
  parameter int GAP     = -1,
  parameter int BitAddr = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BitAddr:0] len_a,
  input  logic [BitAddr:0] len_b,
  input  logic             calc_done,
  output logic             en_init,
  output logic             en_ins_read,
  output logic             we,
  output logic [BitAddr:0] addr,
  output logic [BitAddr:0] i,
  output logic [BitAddr:0] j,
  output logic [8:0]       data,
  output logic             calc_start,
  output logic             busy,
  output logic             done
);

  localparam int AW = BitAddr + 1;
  localparam logic [BitAddr:0] LenMax = AW'(N);

  typedef enum logic [2:0] {
    StIdle, StInit, StRd, StRdWait, StCalcStart, StCalcWait, StWr, StDone
  } state_e;

  state_e state_q, state_d;
  logic [BitAddr:0] lena_q, lena_d, lenb_q, lenb_d, lmax_q, lmax_d;
  logic [BitAddr:0] addr_q, addr_d, i_q, i_d, j_q, j_d;
  logic [BitAddr:0] lena_clamp, lenb_clamp;

  always_comb begin
    lena_clamp = (len_a > LenMax) ? LenMax : len_a;
    lenb_clamp = (len_b > LenMax) ? LenMax : len_b;
  end

  always_comb begin
    state_d = state_q;
    lena_d  = lena_q;
    lenb_d  = lenb_q;
    lmax_d  = lmax_q;
    addr_d  = addr_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          lena_d  = lena_clamp;
          lenb_d  = lenb_clamp;
          lmax_d  = (lena_clamp > lenb_clamp) ? lena_clamp : lenb_clamp;
          addr_d  = '0;
          state_d = StInit;
        end
      end
      StInit: begin
        if (addr_q == lmax_q) begin
          i_d     = '0;
          j_d     = '0;
          state_d = (lena_q != '0 && lenb_q != '0) ? StRd : StDone;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      StRd:        state_d = StRdWait;
      StRdWait:    state_d = StCalcStart;
      // calc_done is not looked at in the request cycle; a stale high must not skip the wait.
      StCalcStart: state_d = StCalcWait;
      StCalcWait:  if (calc_done) state_d = StWr;
      StWr: begin
        if (i_q + AW'(1) < lena_q) begin
          i_d     = i_q + AW'(1);
          state_d = StRd;
        end else if (j_q + AW'(1) < lenb_q) begin
          i_d     = '0;
          j_d     = j_q + AW'(1);
          state_d = StRd;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        addr_d  = '0;
        i_d     = '0;
        j_d     = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      lena_q  <= '0;
      lenb_q  <= '0;
      lmax_q  <= '0;
      addr_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      lena_q  <= lena_d;
      lenb_q  <= lenb_d;
      lmax_q  <= lmax_d;
      addr_q  <= addr_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    en_init     = (state_q == StInit);
    en_ins_read = (state_q == StRd) || (state_q == StRdWait) || (state_q == StCalcStart) ||
                  (state_q == StCalcWait) || (state_q == StWr);
    we          = (state_q == StInit) || (state_q == StWr);
    calc_start  = (state_q == StCalcStart);
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    addr        = addr_q;
    i           = i_q;
    j           = j_q;
    data        = 9'(GAP * $signed(32'(addr_q)));
  end

endmodule

// File: tb/tb_nw_fill_ctrl.sv
// Directed bench for nw_fill_ctrl with N=8, GAP=-1: table of full runs plus reset/abort sequences.
module tb_nw_fill_ctrl;

  localparam int N = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] len_a, len_b;
  logic          calc_done;
  logic          en_init, en_ins_read, we, calc_start, busy, done;
  logic [AW-1:0] addr, i, j;
  logic [8:0]    data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nw_fill_ctrl #(.N(N), .GAP(-1)) dut (
    .clk(clk), .rst(rst), .start(start), .len_a(len_a), .len_b(len_b),
    .calc_done(calc_done), .en_init(en_init), .en_ins_read(en_ins_read), .we(we),
    .addr(addr), .i(i), .j(j), .data(data), .calc_start(calc_start), .busy(busy),
    .done(done)
  );

  typedef struct {
    int la, lb;
    bit stall, busy_st;
    int done_cyc, init_wr, fill_wr, calcs, max_addr, max_i, max_j, run;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, int'({en_init, en_ins_read, we, calc_start, busy, done}), 0);
    chk({name, "_idx"}, int'({addr, i, j, data}), 0);
  endtask

  task automatic run_case(input vec_t v);
    int cyc, init_wr, fill_wr, calcs, max_addr, max_i, max_j, done_cyc, run_len, since_cs;
    int la_c, ci, cj, overlap, unstable, not_busy;
    bit seen_done;
    la_c = (v.la > N) ? N : v.la;
    {cyc, init_wr, fill_wr, calcs, max_addr, max_i, max_j, run_len} = '0;
    {ci, cj, overlap, unstable, not_busy} = '0;
    done_cyc = -1;
    since_cs = 100;
    seen_done = 1'b0;
    @(posedge clk); #1;
    chk("idle_before_start", int'(busy), 0);
    len_a = AW'(v.la);
    len_b = AW'(v.lb);
    start = 1'b1;
    calc_done = 1'b1;
    while (!seen_done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start = v.busy_st && (cyc % 7 == 3);
      if (start) begin
        len_a = 4'd1;
        len_b = 4'd1;
      end
      if (!busy) not_busy++;
      if (en_init && en_ins_read) overlap++;
      if (en_init) begin
        chk("init_addr", int'(addr), init_wr);
        chk("init_data", int'(data), (512 - init_wr) % 512);
        chk("init_we", int'(we), 1);
        if (int'(addr) > max_addr) max_addr = int'(addr);
        init_wr++;
      end
      if (en_ins_read) begin
        if (int'(i) > max_i) max_i = int'(i);
        if (int'(j) > max_j) max_j = int'(j);
        if (we) begin
          chk("cell_i", int'(i), fill_wr % la_c);
          chk("cell_j", int'(j), fill_wr / la_c);
          chk("read_cycles", run_len, v.run);
          run_len = 0;
          fill_wr++;
        end else begin
          if (run_len > 0 && (int'(i) != ci || int'(j) != cj)) unstable++;
          ci = int'(i);
          cj = int'(j);
          run_len++;
        end
      end
      if (calc_start) begin
        calcs++;
        since_cs = 0;
      end else begin
        since_cs++;
      end
      calc_done = !v.stall || since_cs >= 3;
      if (done) begin
        seen_done = 1'b1;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    chk("done_cycle", done_cyc, v.done_cyc);
    chk("init_writes", init_wr, v.init_wr);
    chk("fill_writes", fill_wr, v.fill_wr);
    chk("calc_starts", calcs, v.calcs);
    chk("max_addr", max_addr, v.max_addr);
    chk("max_i", max_i, v.max_i);
    chk("max_j", max_j, v.max_j);
    chk("enable_overlap", overlap, 0);
    chk("ij_unstable", unstable, 0);
    chk("busy_gap", not_busy, 0);
    @(posedge clk); #1;
    chk_all_zero("post_done_idle");
  endtask

  initial begin
    vecs[0] = '{3, 2, 0, 0, 35, 4, 6, 6, 3, 2, 1, 4};
    vecs[1] = '{3, 2, 1, 0, 47, 4, 6, 6, 3, 2, 1, 6};
    vecs[2] = '{0, 4, 0, 0, 6, 5, 0, 0, 4, 0, 0, 4};
    vecs[3] = '{9, 1, 0, 0, 50, 9, 8, 8, 8, 7, 0, 4};
    vecs[4] = '{1, 1, 0, 0, 8, 2, 1, 1, 1, 0, 0, 4};
    vecs[5] = '{2, 9, 0, 0, 90, 9, 16, 16, 8, 1, 7, 4};
    vecs[6] = '{0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 4};
    vecs[7] = '{3, 2, 0, 1, 35, 4, 6, 6, 3, 2, 1, 4};

    // Reset held with start asserted.
    rst = 1'b0;
    start = 1'b1;
    len_a = 4'd3;
    len_b = 4'd2;
    calc_done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk_all_zero("reset_hold");
    end
    rst = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_all_zero("idle_after_reset");
    end

    for (int v = 0; v < 8; v++) run_case(vecs[v]);

    // Abort in the WR cycle of cell (1,0), then restart cleanly.
    begin
      bit hit;
      hit = 1'b0;
      @(posedge clk); #1;
      len_a = 4'd3;
      len_b = 4'd2;
      start = 1'b1;
      calc_done = 1'b1;
      for (int k = 0; k < 100 && !hit; k++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (we && en_ins_read && i == 4'd1 && j == 4'd0) hit = 1'b1;
      end
      chk("abort_reached_wr", int'(hit), 1);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk_all_zero("abort_reset");
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        chk_all_zero("abort_idle");
      end
    end
    run_case(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
